// File: rtl/bank_sched.sv
// Coefficient-bank scheduler: one shared read address per cycle across every
// NTT/INTT stage, with in-place write-back delayed by the read+butterfly latency.
module bank_sched #(
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned BF_LAT     = 4,
  parameter int unsigned NUM_STAGES = 4,
  parameter int unsigned STG_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic              hold,
  output logic              bank_en,
  output logic              bank_ren,
  output logic              bank_wen,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [STG_W-1:0]  stage,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WR_DLY = BF_LAT + 1;
  localparam int unsigned CNT_W  = ADDR_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_READ, S_DRAIN, S_NEXT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic               mode_q, mode_d;
  logic [ADDR_W-1:0]  last_q;
  logic [WR_DLY-1:0]  pv_q;
  logic [ADDR_W-1:0]  pa_q [WR_DLY];
  logic               last_stage;

  assign last_stage = mode_q ? (stage_q == '0) : (stage_q == STG_W'(NUM_STAGES - 1));

  // cnt doubles as the drain timer, so it is cleared on entry to DRAIN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: if (start) begin
        mode_d  = mode;
        stage_d = mode ? STG_W'(NUM_STAGES - 1) : '0;
        cnt_d   = '0;
        state_d = S_READ;
      end
      S_READ: if (!hold) begin
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: if (!hold) begin
        if (cnt_q == CNT_W'(WR_DLY - 1)) begin
          cnt_d   = '0;
          state_d = last_stage ? S_DONE : S_NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_NEXT: if (!hold) begin
        stage_d = mode_q ? stage_q - STG_W'(1) : stage_q + STG_W'(1);
        cnt_d   = '0;
        state_d = S_READ;
      end
      S_DONE: if (!hold) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      mode_q  <= 1'b0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      mode_q  <= mode_d;
      if (state_q == S_READ && !hold) last_q <= cnt_q[ADDR_W-1:0];
    end
  end

  // Write-back pipeline: {valid, addr} of every issued read, WR_DLY cycles late
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int unsigned i = 0; i < WR_DLY; i++) pa_q[i] <= '0;
    end else if (!hold) begin
      for (int unsigned i = 1; i < WR_DLY; i++) begin
        pv_q[i] <= pv_q[i-1];
        pa_q[i] <= pa_q[i-1];
      end
      pv_q[0] <= (state_q == S_READ);
      pa_q[0] <= rd_addr;
    end
  end

  assign rd_addr  = (state_q == S_READ) ? cnt_q[ADDR_W-1:0] : last_q;
  assign wr_addr  = pa_q[WR_DLY-1];
  assign bank_wen = pv_q[WR_DLY-1] & ~hold;
  assign bank_ren = (state_q == S_READ) & ~hold;
  assign bank_en  = ((state_q == S_READ) || (state_q == S_DRAIN) || (state_q == S_NEXT)) & ~hold;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE) & ~hold;
  assign stage    = stage_q;

endmodule

// File: tb/tb_bank_sched.sv
// Bench for bank_sched: two instances (default parameters and BF_LAT=1/NUM_STAGES=1)
// checked every cycle against a timeline model derived from the stage period.
module tb_bank_sched;
  localparam int DEPTH = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] start_v, mode_v, hold_v;
  logic [1:0] en_v, ren_v, wen_v, busy_v, done_v;
  logic [6:0] rd_v [2];
  logic [6:0] wr_v [2];
  logic [3:0] stg_v [2];

  bank_sched u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode_v[0]), .hold(hold_v[0]),
    .bank_en(en_v[0]), .bank_ren(ren_v[0]), .bank_wen(wen_v[0]),
    .rd_addr(rd_v[0]), .wr_addr(wr_v[0]), .stage(stg_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );

  bank_sched #(.ADDR_W(7), .DEPTH(128), .BF_LAT(1), .NUM_STAGES(1), .STG_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode_v[1]), .hold(hold_v[1]),
    .bank_en(en_v[1]), .bank_ren(ren_v[1]), .bank_wen(wen_v[1]),
    .rd_addr(rd_v[1]), .wr_addr(wr_v[1]), .stage(stg_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );

  int checks = 0;
  int errors = 0;

  // Model: t counts un-held cycles since the start edge; everything else follows
  // from t and the stage period DEPTH + write delay + 1.
  bit m_act [2];
  int m_t [2];
  bit m_mode [2];
  int m_stage [2];
  int m_last [2];

  function automatic int wd(int d); return (d == 0) ? 5 : 2; endfunction
  function automatic int ns(int d); return (d == 0) ? 4 : 1; endfunction
  function automatic int per(int d); return DEPTH + wd(d) + 1; endfunction

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_act[d] = 0; m_t[d] = 0; m_mode[d] = 0; m_stage[d] = 0; m_last[d] = 0;
    end
  endfunction

  function automatic logic [22:0] expv(int d, bit h);
    logic en, ren, wen, bsy, dn;
    logic [3:0] st;
    logic [6:0] rd, wr;
    int ph, s, tot;
    if (!m_act[d]) return {5'b0, 4'(m_stage[d]), 7'(m_last[d]), 7'd0};
    tot = ns(d) * per(d);
    ph  = m_t[d] % per(d);
    s   = m_t[d] / per(d);
    en  = !h && (m_t[d] != tot - 1);
    ren = !h && (ph < DEPTH);
    wen = !h && (ph >= wd(d)) && (ph < wd(d) + DEPTH);
    bsy = 1'b1;
    dn  = !h && (m_t[d] == tot - 1);
    st  = 4'(m_mode[d] ? ns(d) - 1 - s : s);
    rd  = 7'((ph < DEPTH) ? ph : DEPTH - 1);
    wr  = wen ? 7'(ph - wd(d)) : 7'd0;
    return {en, ren, wen, bsy, dn, st, rd, wr};
  endfunction

  function automatic logic [22:0] obsv(int d);
    return {en_v[d], ren_v[d], wen_v[d], busy_v[d], done_v[d], stg_v[d], rd_v[d],
            wen_v[d] ? wr_v[d] : 7'd0};
  endfunction

  function automatic void adv(int d);
    if (m_act[d]) begin
      if (!hold_v[d]) begin
        m_t[d]++;
        if (m_t[d] == ns(d) * per(d)) begin
          m_act[d]   = 0;
          m_stage[d] = m_mode[d] ? 0 : ns(d) - 1;
          m_last[d]  = DEPTH - 1;
        end
      end
    end else if (start_v[d]) begin
      m_act[d] = 1; m_t[d] = 0; m_mode[d] = mode_v[d];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    adv(0); adv(1);
    #1;
  endtask

  task automatic test_reset();
    logic [29:0] o;
    rst_n = 1'b0; start_v = '0; mode_v = '0; hold_v = '0;
    model_reset();
    #3;
    for (int d = 0; d < 2; d++) begin
      o = {obsv(d), wr_v[d]};
      checks++;
      if (o !== '0) begin
        errors++; $display("FAIL reset_outputs dut%0d got %h expected 0", d, o);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_transform(int d, bit md, string name);
    logic [22:0] o, e;
    start_v[d] = 1'b1; mode_v[d] = md; hold_v[d] = 1'b0;
    for (int c = 0; c < 700; c++) begin
      #1;
      o = obsv(d); e = expv(d, hold_v[d]);
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL %s cycle %0d got %h expected %h", name, c, o, e);
      end
      tick();
      start_v[d] = 1'b0;
      mode_v[d]  = 1'($urandom);
      if (!m_act[d]) break;
    end
    checks++;
    if (m_act[d]) begin
      errors++; $display("FAIL %s_timeout got busy expected done", name);
    end
  endtask

  task automatic test_hold_at_50();
    logic [22:0] o, e;
    int hc = 0;
    start_v[0] = 1'b1; mode_v[0] = 1'b0;
    for (int c = 0; c < 700; c++) begin
      hold_v[0] = (m_act[0] && m_t[0] == 50 && hc < 10);
      if (hold_v[0]) hc++;
      #1;
      o = obsv(0); e = expv(0, hold_v[0]);
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL hold50 cycle %0d got %h expected %h", c, o, e);
      end
      tick();
      start_v[0] = 1'b0;
      if (!m_act[0]) break;
    end
    hold_v[0] = 1'b0;
    checks++;
    if (m_act[0] || hc != 10) begin
      errors++; $display("FAIL hold50_timeout got act=%0d holds=%0d expected 0/10", m_act[0], hc);
    end
  endtask

  task automatic test_start_during_busy_random_hold(int d);
    logic [22:0] o, e;
    start_v[d] = 1'b1; mode_v[d] = 1'($urandom);
    for (int c = 0; c < 2000; c++) begin
      hold_v[d] = ($urandom_range(0, 15) == 0);
      #1;
      o = obsv(d); e = expv(d, hold_v[d]);
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL rand_busy dut%0d cycle %0d got %h expected %h", d, c, o, e);
      end
      tick();
      start_v[d] = ($urandom_range(0, 7) == 0);
      mode_v[d]  = 1'($urandom);
      if (!m_act[d]) break;
    end
    start_v[d] = 1'b0; hold_v[d] = 1'b0;
    checks++;
    if (m_act[d]) begin
      errors++; $display("FAIL rand_busy_timeout dut%0d got busy expected done", d);
    end
  endtask

  task automatic test_start_with_hold();
    logic [22:0] o, e;
    start_v[1] = 1'b1; mode_v[1] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      hold_v[1] = (c < 4);
      #1;
      o = obsv(1); e = expv(1, hold_v[1]);
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL start_hold cycle %0d got %h expected %h", c, o, e);
      end
      tick();
      start_v[1] = 1'b0;
      if (!m_act[1]) break;
    end
    hold_v[1] = 1'b0;
    checks++;
    if (m_act[1]) begin
      errors++; $display("FAIL start_hold_timeout got busy expected done");
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] o, e;
    logic [29:0] z;
    start_v[0] = 1'b1; mode_v[0] = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      o = obsv(0); e = expv(0, 1'b0);
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL reset_mid_pre cycle %0d got %h expected %h", c, o, e);
      end
      tick();
      start_v[0] = 1'b0;
    end
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    z = {obsv(0), wr_v[0]};
    checks++;
    if (z !== '0) begin
      errors++; $display("FAIL reset_mid_async got %h expected 0", z);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
        errors++; $display("FAIL reset_mid_held got done=%b busy=%b expected 0", done_v[0], busy_v[0]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_transform(0, 1'b0, "ntt");
    test_transform(0, 1'b1, "intt");
    test_hold_at_50();
    test_start_during_busy_random_hold(0);
    test_start_during_busy_random_hold(0);
    test_reset_mid();
    test_transform(0, 1'b0, "ntt_after_reset");
    test_transform(1, 1'b0, "bf_lat1");
    test_start_with_hold();
    test_start_during_busy_random_hold(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
